fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage. Drives the fetch stage's pc_stall, sel_br and br_targ inputs.
//  Arbitrates between three sources: the post-reset boot hold, decode-stage stalls, and EX-stage branch
//  redirects. On a redirect it emits if_flush so the IF/ID register squashes wrong-path instructions.
// PARAMETERS
//  BOOT_CYCLES  2   cycles pc_stall is held after reset release (>=1)
//  FLUSH_DEPTH  2   cycles if_flush stays high per redirect, counting the REDIRECT cycle (>=1)
//  WORD_BITS    2   low br_targ bits forced to 0 (word alignment)
//  CNT_W        16  width of the perf counters (PERF_CNT_EN only)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  id_stall       in   1        decode requests fetch hold (load-use, etc.)
//  halt           in   1        decode saw a halt; sticky stop
//  br_taken       in   1        EX resolved a taken branch this cycle
//  br_target      in   32       EX branch target address
//  pc_stall       out  1        to fetch: hold PC
//  sel_br         out  1        to fetch: load br_targ into PC
//  br_targ        out  32       to fetch: registered, aligned target
//  if_flush       out  1        to IF/ID register: squash its contents
//  redirect_cnt   out  CNT_W    taken redirects since reset (PERF_CNT_EN only)
//  stall_cnt      out  CNT_W    RUN cycles with pc_stall=1 (PERF_CNT_EN only)
// BEHAVIOUR
//  - States: BOOT, RUN, REDIRECT, FLUSH, HALT. State, br_targ and counters are flops.
//  - Reset (async): state=BOOT, boot counter=0, flush counter=0, br_targ=0, all counters=0.
//    Outputs during reset: pc_stall=1, sel_br=0, if_flush=0.
//  - BOOT: pc_stall=1. Moves to RUN after BOOT_CYCLES clock edges. br_taken, id_stall and halt are ignored.
//  - RUN: pc_stall=id_stall (combinational pass-through); sel_br=0; if_flush=0.
//  - Redirect: br_taken=1 is sampled in RUN, REDIRECT or FLUSH.
//    * At that edge: br_targ <= {br_target[31:WORD_BITS], WORD_BITS'b0}; state <= REDIRECT.
//  - REDIRECT (exactly 1 cycle): sel_br=1, pc_stall=0, if_flush=1; PC loads br_targ at the end of it.
//    * Next state is FLUSH if FLUSH_DEPTH>1, otherwise RUN.
//  - FLUSH: if_flush=1, pc_stall=0, sel_br=0; id_stall is ignored (squashed instructions are younger).
//    * Lasts FLUSH_DEPTH-1 cycles, then RUN.
//  - Redirect latency: br_taken at cycle T -> sel_br at T+1 -> target fetched at T+2.
//    if_flush is high for cycles T+1..T+FLUSH_DEPTH.
//  - HALT: entered from RUN when halt=1 and br_taken=0. pc_stall=1, sel_br=0, if_flush=0.
//    Left only by reset.
//  - Priority in the same cycle: br_taken > halt > id_stall.
//    * A branch arriving with a stall or halt redirects; the stalled or halting instruction is younger and flushed.
//  - br_taken during REDIRECT or FLUSH: latest target wins. REDIRECT restarts and the flush count reloads.
//  - halt during REDIRECT or FLUSH is ignored (it comes from a wrong-path instruction).
//  - Reset mid-redirect: all state is discarded immediately; pc_stall=1 at once.
// CONFIGURATION
//  FETCH_CTRL_PERF_CNT_EN defined:
//   - redirect_cnt increments on every accepted br_taken.
//   - stall_cnt increments on every RUN cycle with id_stall=1.
//   - Both saturate at all-ones and reset to 0.
//  Not defined: both ports tie to 0; no counter flops are instantiated.
// TESTING
//  1 Release reset, BOOT_CYCLES=2, no inputs -> pc_stall=1 for 2 cycles, then 0; sel_br=0 and if_flush=0 throughout.
//  2 In RUN, br_taken=1 with br_target=32'h0000_0027 at T
//    -> T+1: sel_br=1, br_targ=32'h0000_0024, if_flush=1; T+2: if_flush=1, sel_br=0; T+3: if_flush=0.
//  3 In RUN, id_stall=1 for 3 cycles -> pc_stall=1 for exactly those 3 cycles; stall_cnt=3 (PERF on).
//  4 Same cycle: id_stall=1, halt=1, br_taken=1 (target 32'h40) -> REDIRECT to 32'h40, no HALT.
//    Later halt=1 alone -> pc_stall stays 1 until rst.
//  5 br_taken to 32'h10 at T, br_taken to 32'h80 at T+1 -> sel_br=1 at T+1 (br_targ=32'h10)
//    and at T+2 (br_targ=32'h80); if_flush high T+1..T+3; redirect_cnt=2.
//  6 Assert rst during FLUSH -> same cycle pc_stall=1 and if_flush=0; BOOT sequence repeats; counters read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: boot hold, decode stalls, branch redirects with IF/ID flush.
// Optional perf counters are enabled by defining FETCH_CTRL_PERF_CNT_EN.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned WORD_BITS   = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             halt,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic             pc_stall,
    output logic             sel_br,
    output logic [31:0]      br_targ,
    output logic             if_flush,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned BW = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FLUSH_DEPTH + 1);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << WORD_BITS) - 32'd1);

    typedef enum logic [2:0] {BOOT, RUN, REDIRECT, FLUSH, HALT} state_t;

    state_t        state;
    state_t        nxt;
    logic [BW-1:0] boot_cnt;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          hold_q;
    logic          run_q;

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        case (state)
            BOOT: begin
                if (boot_cnt == BW'(BOOT_CYCLES - 1))
                    nxt = RUN;
            end
            RUN: begin
                if (br_taken) begin
                    nxt    = REDIRECT;
                    accept = 1'b1;
                end else if (halt) begin
                    nxt = HALT;
                end
            end
            REDIRECT: begin
                if (br_taken) begin
                    nxt    = REDIRECT;
                    accept = 1'b1;
                end else begin
                    nxt = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (br_taken) begin
                    nxt    = REDIRECT;
                    accept = 1'b1;
                end else if (flush_cnt == FW'(1)) begin
                    nxt = RUN;
                end
            end
            HALT:    nxt = HALT;
            default: nxt = BOOT;
        endcase
    end

    // Output flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            flush_cnt <= '0;
            br_targ   <= '0;
            sel_br    <= 1'b0;
            if_flush  <= 1'b0;
            hold_q    <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            state    <= nxt;
            sel_br   <= (nxt == REDIRECT);
            if_flush <= (nxt == REDIRECT) || (nxt == FLUSH);
            hold_q   <= (nxt == BOOT) || (nxt == HALT);
            run_q    <= (nxt == RUN);
            if (state == BOOT && nxt == BOOT)
                boot_cnt <= boot_cnt + BW'(1);
            if (accept)
                br_targ <= br_target & ALIGN_MASK;
            if (nxt == REDIRECT)
                flush_cnt <= FW'(FLUSH_DEPTH - 1);
            else if (state == FLUSH)
                flush_cnt <= flush_cnt - FW'(1);
        end
    end

    assign pc_stall = run_q ? id_stall : hold_q;

`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] redir_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept && redir_q != '1)
                redir_q <= redir_q + CNT_W'(1);
            if (state == RUN && id_stall && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign redirect_cnt = redir_q;
    assign stall_cnt    = stall_q;
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle vector table plus reset/boot sequences.
// Counter expectations follow FETCH_CTRL_PERF_CNT_EN.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        halt;
    logic        br_taken;
    logic [31:0] br_target;
    logic        pc_stall;
    logic        sel_br;
    logic [31:0] br_targ;
    logic        if_flush;
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    fetch_ctrl #(
        .BOOT_CYCLES(2),
        .FLUSH_DEPTH(2),
        .WORD_BITS(2),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_stall(id_stall),
        .halt(halt),
        .br_taken(br_taken),
        .br_target(br_target),
        .pc_stall(pc_stall),
        .sel_br(sel_br),
        .br_targ(br_targ),
        .if_flush(if_flush),
        .redirect_cnt(redirect_cnt),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic        hl;
        logic        br;
        logic [31:0] tgt;
        logic        e_pc;
        logic        e_sel;
        logic [31:0] e_targ;
        logic        e_fl;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_pc, input logic e_sel,
                            input logic [31:0] e_targ, input logic e_fl);
        chk({tag, ".pc_stall"}, {31'b0, pc_stall}, {31'b0, e_pc});
        chk({tag, ".sel_br"},   {31'b0, sel_br},   {31'b0, e_sel});
        chk({tag, ".br_targ"},  br_targ,           e_targ);
        chk({tag, ".if_flush"}, {31'b0, if_flush}, {31'b0, e_fl});
    endtask

    task automatic drive(input logic id, input logic hl, input logic br, input logic [31:0] tgt);
        id_stall  = id;
        halt      = hl;
        br_taken  = br;
        br_target = tgt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_redir;
    logic [15:0] exp_stall;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 32'h0);

        //           id hl br tgt            pc sel targ           fl
        vt[0]  = '{1'b0, 1'b0, 1'b1, 32'h55,  1'b1, 1'b0, 32'h0,  1'b0}; // BOOT ignores branch
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  1'b0}; // BOOT ignores halt
        vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h27,  1'b0, 1'b0, 32'h0,  1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h24, 1'b1}; // REDIRECT, halt ignored
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h24, 1'b1}; // FLUSH, stall ignored
        vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h24, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h24, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h24, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h24, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 32'h40,  1'b1, 1'b0, 32'h24, 1'b0}; // branch beats halt+stall
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h40, 1'b1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h40, 1'b1};
        vt[13] = '{1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b0, 32'h40, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 1'b1, 32'h10, 1'b1}; // back-to-back redirect
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h80, 1'b1};
        vt[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h80, 1'b1};
        vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h80, 1'b0};
        vt[18] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h80, 1'b0};
        vt[19] = '{1'b0, 1'b0, 1'b1, 32'h99,  1'b1, 1'b0, 32'h80, 1'b0}; // HALT is sticky
        vt[20] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h80, 1'b0};

`ifdef FETCH_CTRL_PERF_CNT_EN
        exp_redir = 16'd4;
        exp_stall = 16'd4;
`else
        exp_redir = 16'd0;
        exp_stall = 16'd0;
`endif

        #2;
        chk_outs("reset", 1'b1, 1'b0, 32'h0, 1'b0);
        chk("reset.redirect_cnt", {16'b0, redirect_cnt}, 32'd0);
        chk("reset.stall_cnt",    {16'b0, stall_cnt},    32'd0);

        next_cycle();
        rst = 1'b0;

        for (int unsigned i = 0; i < 21; i++) begin
            drive(vt[i].id, vt[i].hl, vt[i].br, vt[i].tgt);
            #3;
            chk_outs($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_sel, vt[i].e_targ, vt[i].e_fl);
            if (i == 17) begin
                chk("vec17.redirect_cnt", {16'b0, redirect_cnt}, {16'b0, exp_redir});
                chk("vec17.stall_cnt",    {16'b0, stall_cnt},    {16'b0, exp_stall});
            end
            next_cycle();
        end

        // Reset out of HALT, boot again, then reset in the middle of FLUSH.
        drive(0, 0, 0, 32'h0);
        rst = 1'b1;
        #2;
        chk_outs("halt_rst", 1'b1, 1'b0, 32'h0, 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            #3;
            chk_outs($sformatf("reboot%0d", i), 1'b1, 1'b0, 32'h0, 1'b0);
            next_cycle();
        end
        drive(0, 0, 1, 32'h123);
        #3;
        chk_outs("run_br", 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 32'h0);
        #3;
        chk_outs("redir", 1'b0, 1'b1, 32'h120, 1'b1);
        next_cycle();
        #1;
        chk_outs("flush", 1'b0, 1'b0, 32'h120, 1'b1);
        rst = 1'b1;
        #1;
        chk_outs("flush_rst", 1'b1, 1'b0, 32'h0, 1'b0);
        chk("flush_rst.redirect_cnt", {16'b0, redirect_cnt}, 32'd0);
        chk("flush_rst.stall_cnt",    {16'b0, stall_cnt},    32'd0);
        next_cycle();
        rst = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            #3;
            chk_outs($sformatf("boot2_%0d", i), 1'b1, 1'b0, 32'h0, 1'b0);
            next_cycle();
        end
        #3;
        chk_outs("boot2_run", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
